// File: rtl/nios2_debug_jtag_scan_master.sv
// nios2_debug_jtag_scan_master
//
// System-clock JTAG initiator. Walks the TAP from Run-Test/Idle through one
// IR or DR scan and back to Run-Test/Idle, returning the bits seen on tdo.
// After reset it first drives five tms=1 steps and one tms=0 step so the
// target TAP is known to sit in Run-Test/Idle.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (one scan at a time, no queueing)
//   cmd_is_ir             1 = IR scan (IR_WIDTH bits), 0 = DR scan
//   cmd_len               DR length; 0 or > DR_WIDTH means DR_WIDTH
//   cmd_data              bits shifted out on tdi, LSB first
//   rsp_valid             one-clk pulse when a scan completes
//   rsp_data              captured tdo bits, bit i = i-th shifted bit
//   busy                  reset sequence or scan in progress
//   tck, tms, tdi, tdo    JTAG pins
//
// state | meaning
// ------+----------------------------------------------------------
// INIT  | 5x tms=1 then 1x tms=0, parks the target in Run-Test/Idle
// IDLE  | waiting for a command, tck=0, tms=0
// PRE   | Run-Test/Idle -> Shift-DR (1,0,0) or Shift-IR (1,1,0,0)
// SHIFT | N shift steps, tms=1 on the last one (Exit1)
// POST  | Update (tms=1) then Run-Test/Idle (tms=0)
// DONE  | drop tck, pulse rsp_valid (not after INIT), raise cmd_ready

module nios2_debug_jtag_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_is_ir,
  input  logic [5:0]          cmd_len,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                busy,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  localparam int LEN_W = 6;
  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]          state;
  logic [DIV_W-1:0]    div_cnt;
  logic                rise_next;   // 0: next half-period event is a falling edge
  logic [LEN_W-1:0]    step_cnt;    // step index within the current state
  logic                is_ir;
  logic [LEN_W-1:0]    eff_len;
  logic [DR_WIDTH-1:0] data_sr;
  logic                scan_mode;   // 0 while the post-reset INIT sequence runs

  logic                tick;
  logic                accept;
  logic                tms_step;
  logic                last_step;
  logic [2:0]          state_after;

  assign tick   = (div_cnt == DIV_W'(TCK_DIV - 1));
  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    tms_step    = 1'b0;
    last_step   = 1'b0;
    state_after = S_DONE;
    case (state)
      S_INIT: begin
        tms_step  = (step_cnt < 6'd5);
        last_step = (step_cnt == 6'd5);
      end
      S_PRE: begin
        tms_step    = (step_cnt == 6'd0) || (is_ir && (step_cnt == 6'd1));
        last_step   = (step_cnt == (is_ir ? 6'd3 : 6'd2));
        state_after = S_SHIFT;
      end
      S_SHIFT: begin
        last_step   = (step_cnt == (eff_len - 6'd1));
        tms_step    = last_step;
        state_after = S_POST;
      end
      S_POST: begin
        tms_step  = (step_cnt == 6'd0);
        last_step = (step_cnt == 6'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT;
      div_cnt   <= '0;
      rise_next <= 1'b0;
      step_cnt  <= '0;
      is_ir     <= 1'b0;
      eff_len   <= '0;
      data_sr   <= '0;
      scan_mode <= 1'b0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          tck     <= 1'b0;
          tms     <= 1'b0;
          div_cnt <= '0;
          if (accept) begin
            is_ir     <= cmd_is_ir;
            data_sr   <= cmd_data;
            rsp_data  <= '0;
            scan_mode <= 1'b1;
            if (cmd_is_ir)
              eff_len <= LEN_W'(IR_WIDTH);
            else if ((cmd_len == 6'd0) || (cmd_len > LEN_W'(DR_WIDTH)))
              eff_len <= LEN_W'(DR_WIDTH);
            else
              eff_len <= cmd_len;
            step_cnt  <= '0;
            rise_next <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_PRE;
          end
        end
        S_DONE: begin
          tck       <= 1'b0;
          tms       <= 1'b0;
          div_cnt   <= '0;
          rise_next <= 1'b0;
          rsp_valid <= scan_mode;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        S_INIT, S_PRE, S_SHIFT, S_POST: begin
          if (!tick) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!rise_next) begin
              // falling edge: present tms/tdi for the step about to complete
              tck       <= 1'b0;
              tms       <= tms_step;
              rise_next <= 1'b1;
              if (state == S_SHIFT)
                tdi <= data_sr[step_cnt];
            end else begin
              tck       <= 1'b1;
              rise_next <= 1'b0;
              if (state == S_SHIFT)
                rsp_data[step_cnt] <= tdo;
              if (last_step) begin
                step_cnt <= '0;
                state    <= state_after;
              end else begin
                step_cnt <= step_cnt + 6'd1;
              end
            end
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
